// File: rtl/euler_result_uart_tx.sv
// Captures a solver result on the rising edge of done, converts it to decimal with sequential
// double-dabble and sends the digits followed by CR LF as UART 8N1.
// Optional feature macro: EULER_TX_OVF_REPORT_EN (send "OVF" CR LF when overflow was captured).
module euler_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] result,
  input  logic        overflow,
  input  logic        done,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_PICK, S_START, S_DATA, S_STOP, S_FIN
  } state_t;

  typedef enum logic [1:0] {PH_DIG, PH_OVF, PH_CR, PH_LF} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, pick_phase, next_phase;
  logic [3:0]  idx_q, pick_idx, next_idx;
  logic [31:0] bin_q;
  logic [39:0] bcd_q, bcd_adj;
  logic [4:0]  step_q;
  logic [2:0]  bit_q;
  logic [15:0] timer_q;
  logic [7:0]  char_q;
  logic        done_q, tx_d, capture, bit_end;

`ifdef EULER_TX_OVF_REPORT_EN
  logic ovf_q;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  assign capture = done & ~done_q & ~busy;
  assign bit_end = (timer_q == 16'(CLKS_PER_BIT - 1));

  function automatic logic [39:0] dabble(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] char_of(input phase_t ph, input logic [3:0] idx,
                                         input logic [39:0] bcd);
    logic [7:0] c;
    case (ph)
      PH_DIG:  c = {4'h3, bcd[{idx, 2'b00} +: 4]};
      PH_OVF:  c = (idx == 4'd2) ? 8'h4F : (idx == 4'd1) ? 8'h56 : 8'h46;
      PH_CR:   c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  assign bcd_adj = dabble(bcd_q);

  // First character: most significant nonzero digit, or digit 0 so a zero value prints "0".
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    pick_phase = PH_DIG;
    pick_idx   = 4'd0;
    for (int i = 0; i < 10; i++)
      if (bcd_q[4*i +: 4] != 4'd0) pick_idx = 4'(i);
`ifdef EULER_TX_OVF_REPORT_EN
    if (ovf_q) begin
      pick_phase = PH_OVF;
      pick_idx   = 4'd2;
    end
`endif
  end

  always_comb begin
    next_phase = phase_q;
    next_idx   = idx_q;
    case (phase_q)
      PH_DIG, PH_OVF: begin
        if (idx_q != 4'd0) next_idx = idx_q - 4'd1;
        else               next_phase = PH_CR;
      end
      default: next_phase = PH_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture) state_d = S_CONV;
      S_CONV:  if (step_q == 5'd31) state_d = S_PICK;
      S_PICK:  state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = (phase_q == PH_LF) ? S_FIN : S_START;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = char_q[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  // tx is registered, so the line lags the state by one clock (start bit appears on edge 34).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      char_q  <= '0;
      phase_q <= PH_DIG;
      idx_q   <= '0;
`ifdef EULER_TX_OVF_REPORT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= done;
      tx     <= tx_d;
      case (state_q)
        S_IDLE: if (capture) begin
          bin_q   <= result;
          bcd_q   <= '0;
          step_q  <= '0;
          busy    <= 1'b1;
          tx_done <= 1'b0;
`ifdef EULER_TX_OVF_REPORT_EN
          ovf_q   <= overflow;
`endif
        end
        S_CONV: begin
          bcd_q  <= {bcd_adj[38:0], bin_q[31]};
          bin_q  <= {bin_q[30:0], 1'b0};
          step_q <= step_q + 5'd1;
        end
        S_PICK: begin
          phase_q <= pick_phase;
          idx_q   <= pick_idx;
          char_q  <= char_of(pick_phase, pick_idx, bcd_q);
          timer_q <= '0;
          bit_q   <= '0;
        end
        S_START, S_DATA, S_STOP: begin
          timer_q <= bit_end ? '0 : timer_q + 16'd1;
          if (bit_end && state_q == S_DATA) bit_q <= bit_q + 3'd1;
          if (bit_end && state_q == S_STOP) begin
            phase_q <= next_phase;
            idx_q   <= next_idx;
            char_q  <= char_of(next_phase, next_idx, bcd_q);
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          tx_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_euler_result_uart_tx.sv
// Self-checking bench for euler_result_uart_tx: randomized and directed results, line decoded
// by a mid-bit UART receiver and compared with a decimal-string reference model.
module tb_euler_result_uart_tx;

  localparam int C = 4;
`ifdef EULER_TX_OVF_REPORT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] result = '0;
  logic        overflow = 1'b0;
  logic        done = 1'b0;
  logic        tx, busy, tx_done;

  int checks = 0;
  int errors = 0;

  logic tx_s[$];
  logic busy_s[$];
  logic tdone_s[$];
  bq_t  rx;
  int   ferr;

  euler_result_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .overflow(overflow), .done(done),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Reference: the decimal text of the value, or "OVF" when overflow reporting is built in.
  function automatic bq_t model_stream(input logic [31:0] v, input bit ovf);
    bq_t q;
    longint unsigned x;
    x = longint'(v);
    if (ovf && OVF_EN) begin
      q = '{8'h4F, 8'h56, 8'h46, 8'h0D, 8'h0A};
      return q;
    end
    if (x == 0) q.push_back(8'h30);
    while (x != 0) begin
      q.push_front(8'(64'h30 + x % 10));
      x = x / 10;
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  // Samples taken 1 time unit after each rising edge; index 0 follows the capture edge.
  task automatic collect(input int budget, output bit timed_out);
    tx_s.delete(); busy_s.delete(); tdone_s.delete();
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      tx_s.push_back(tx);
      busy_s.push_back(busy);
      tdone_s.push_back(tx_done);
      if (tx_done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  function automatic void decode();
    int i;
    logic [7:0] b;
    rx.delete();
    ferr = 0;
    i = 0;
    while (i < tx_s.size()) begin
      if (tx_s[i] === 1'b0 && i + 38 < tx_s.size()) begin
        for (int j = 0; j < 8; j++) b[j] = tx_s[i + 2 + C * (j + 1)];
        if (tx_s[i + 2] !== 1'b0 || tx_s[i + 38] !== 1'b1) ferr++;
        rx.push_back(b);
        i = i + 38;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full report; with fresh=0 the caller has already arranged a capture on the next edge.
  task automatic test_frame(input logic [31:0] v, input bit ovf, input bit fresh);
    bq_t exp;
    bit  to;
    int  fz, bcnt, n;
    exp = model_stream(v, ovf);
    n = exp.size();
    if (fresh) begin
      @(negedge clk);
      done = 1'b0;
      repeat (2) @(negedge clk);
      result = v;
      overflow = ovf;
      done = 1'b1;
    end
    collect(34 + 10 * 12 * C + 50, to);
    checks++; if (to) begin errors++; $display("FAIL frame_timeout value %0d got no tx_done", v); end
    decode();
    checks++;
    if (rx.size() != n) begin
      errors++; $display("FAIL frame_len value %0d got %0d chars want %0d", v, rx.size(), n);
    end
    for (int i = 0; i < n && i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin
        errors++; $display("FAIL frame_char value %0d idx %0d got %h want %h", v, i, rx[i], exp[i]);
      end
    end
    fz = -1;
    for (int i = 0; i < tx_s.size(); i++) if (fz < 0 && tx_s[i] === 1'b0) fz = i;
    checks++; if (fz != 34) begin errors++; $display("FAIL start_latency value %0d got %0d want 34", v, fz); end
    checks++;
    if (tdone_s.size() - 1 != 34 + 10 * n * C) begin
      errors++; $display("FAIL tx_done_time value %0d got %0d want %0d", v, tdone_s.size() - 1, 34 + 10 * n * C);
    end
    bcnt = 0;
    foreach (busy_s[i]) if (busy_s[i] === 1'b1) bcnt++;
    checks++;
    if (bcnt != 34 + 10 * n * C || busy_s[busy_s.size() - 1] !== 1'b0) begin
      errors++; $display("FAIL busy_width value %0d got %0d want %0d", v, bcnt, 34 + 10 * n * C);
    end
    checks++; if (tdone_s[0] !== 1'b0) begin errors++; $display("FAIL tx_done_clear value %0d got %b want 0", v, tdone_s[0]); end
    checks++; if (ferr != 0) begin errors++; $display("FAIL framing value %0d got %0d bad frames want 0", v, ferr); end
  endtask

  task automatic test_known_values();
    test_frame(32'd4613732, 1'b0, 1'b1);
    test_frame(32'd0, 1'b0, 1'b1);
    test_frame(32'hFFFF_FFFF, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    test_frame(32'd123, 1'b1, 1'b1);
    test_frame(32'd123, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      test_frame($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_hold_done();
    bq_t exp;
    int  rises;
    logic prev_busy;
    exp = model_stream(32'd123, 1'b0);
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    result = 32'd123;
    overflow = 1'b0;
    done = 1'b1;
    rises = 0;
    prev_busy = busy;
    tx_s.delete();
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      tx_s.push_back(tx);
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      if (k == 100) done = 1'b0;
      if (k == 101) done = 1'b1;
    end
    decode();
    checks++; if (rises != 1) begin errors++; $display("FAIL hold_captures got %0d want 1", rises); end
    checks++;
    if (rx.size() != exp.size()) begin
      errors++; $display("FAIL hold_len got %0d chars want %0d", rx.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== exp[i]) begin errors++; $display("FAIL hold_char idx %0d got %h want %h", i, rx[i], exp[i]); end
    end
    checks++;
    if (busy !== 1'b0 || tx_done !== 1'b1) begin
      errors++; $display("FAIL hold_end busy %b tx_done %b want 0 1", busy, tx_done);
    end
  endtask

  task automatic test_back_to_back();
    int n_a, k_end;
    n_a = model_stream(32'd98765, 1'b0).size();
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    result = 32'd98765;
    overflow = 1'b0;
    done = 1'b1;
    k_end = -1;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk); #1;
      if (k == 5) done = 1'b0;
      if (k > 0 && busy === 1'b0) begin
        k_end = k;
        break;
      end
    end
    checks++;
    if (k_end != 34 + 10 * n_a * C || tx_done !== 1'b1) begin
      errors++; $display("FAIL b2b_first_end got %0d want %0d", k_end, 34 + 10 * n_a * C);
    end
    result = 32'd7;
    done = 1'b1;
    test_frame(32'd7, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    result = 32'd4613732;
    overflow = 1'b0;
    done = 1'b1;
    for (int k = 0; k < 130; k++) begin
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL midreset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL midreset_tx_done got %b want 0", tx_done); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_frame(32'd4613732, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    test_reset();
    test_known_values();
    test_overflow();
    test_random();
    test_hold_done();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/euler_result_uart_tx.md
# euler_result_uart_tx

Serial reporter for the Euler solver cores. Watches a solver's `result`/`overflow`/`done` triple, captures the result on the rising edge of `done`, and converts it to unsigned decimal ASCII with sequential double-dabble. It then transmits the digits, followed by CR LF, on a UART 8N1 line. It sits beside any `p00xx` core at the top level and is the consumer end of that core's result interface.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `result`  in  32  solver result; sampled only at the capture edge.
- `overflow`  in  1  solver overflow flag; sampled with `result`.
- `done`  in  1  solver completion level; sticky-high in the solver.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high from the capture edge until the last stop bit ends.
- `tx_done`  out  1  level; set when the last stop bit ends, cleared at the next capture edge.

## Operation
- Edge detect:
  - `done_q` registers `done`.
  - The capture condition is `done & ~done_q & ~busy`.
  - A rising edge while `busy` is ignored and not queued.
  - A `done` held high produces exactly one report.
- Capture: latch `result` into a 32-bit shift register and `overflow` into `ovf_q`, clear the 40-bit BCD register, and enter CONV.
- States:
  - IDLE → CONV on capture.
  - CONV runs 32 double-dabble steps. In each step, add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1. After 32 steps, go to PICK.
  - PICK sets the digit index to the most significant nonzero nibble, or to index 0 if all nibbles are zero (value 0 prints "0"). It loads the first character and goes to START.
  - START holds `tx`=0 for one bit time → DATA.
  - DATA sends 8 bits LSB first, one bit time each → STOP.
  - STOP holds `tx`=1 for one bit time. If characters remain, load the next character → START; otherwise → FIN.
  - FIN sets `tx_done`, clears `busy`, and returns to IDLE.
- Character stream: decimal digits MSB first (0x30+nibble), then 0x0D, then 0x0A. Frame length is 3..12 characters.
- Bit timer counts 0..CLKS_PER_BIT−1 and is reloaded at each bit boundary.
- Reset (any time, including mid-frame):
  - Outputs go immediately to `tx`=1, `busy`=0, `tx_done`=0.
  - State returns to IDLE, and `done_q` is cleared.
  - If `done` is already high after reset release, it is treated as a rising edge on the first clock.

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_done`=0.
- Edge 0 (capture): `busy` rises after this edge.
- Edges 1..32: conversion steps.
- Edge 33: PICK.
- Edge 34: `tx` falls (start bit begins).
- Each character occupies exactly 10·CLKS_PER_BIT cycles. Characters are back-to-back with no idle gap.
- For an N-character frame, `tx_done` rises and `busy` falls on edge 34 + 10·N·CLKS_PER_BIT.
- A capture may occur on the cycle after `busy` falls.

## Configuration
- `EULER_TX_OVF_REPORT_EN`
  - Defined: if `ovf_q`=1, CONV and PICK still take their cycles, but the stream sent is "OVF" CR LF (0x4F 0x56 0x46 0x0D 0x0A) instead of digits. Timing is identical to a 5-character frame.
  - Undefined: `overflow` is ignored, `ovf_q` is not implemented, and the 32-bit `result` is always printed.

## Test plan
- Use CLKS_PER_BIT=4 throughout. Set `result`=4613732, raise `done` → `tx` decodes to 0x34 0x36 0x31 0x33 0x37 0x33 0x32 0x0D 0x0A. `tx` falls 34 cycles after capture, and `tx_done` rises at capture+34+360.
- `result`=0 → "0" CR LF. 3 characters, `busy` width 34+120 cycles.
- `result`=0xFFFFFFFF → "4294967295" CR LF, 12 characters.
- With the macro defined, `overflow`=1, `result`=123 → "OVF" CR LF. With the macro undefined, the same stimulus → "123" CR LF.
- Hold `done` high for 1000 cycles, pulse `done` low then high while `busy` → exactly one frame.
- Assert `rst_n` low during the DATA state of the 3rd character → `tx`=1, `busy`=0, `tx_done`=0 within the same cycle. With `done` still high at reset release, a full fresh frame follows.
